// File: rtl/btn_debounce.sv
// btn_debounce
//   Conditions raw, already-inverted pushbutton inputs for the design core.
//   Each channel goes through a 2-flop synchroniser, a debounce counter that
//   accepts a new level only after it has been stable for DEBOUNCE_CYCLES
//   clocks, and a small FSM that emits auto-repeat ticks while the button is
//   held. All outputs are registered.
//
// Parameters
//   N_BTN           number of independent channels
//   DEBOUNCE_CYCLES clocks a new level must hold before acceptance (>= 1)
//   REPEAT_DELAY    clocks of held level before the first repeat (0 = no repeat)
//   REPEAT_RATE     clocks between subsequent repeats (>= 1)
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw      raw levels, 1 = pressed, asynchronous to clk
//   btn_level    debounced level
//   btn_press    1-cycle pulse on accepted 0->1
//   btn_release  1-cycle pulse on accepted 1->0
//   btn_repeat   1-cycle pulse per auto-repeat tick while held
module btn_debounce #(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] D_LAST     = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = (REPEAT_DELAY > 0) ? RW'(REPEAT_DELAY - 1) : '0;
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] R_SAT      = {RW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_REPEATING = 2'd2
  } state_t;

  // Registered state
  logic [N_BTN-1:0]         sync1;
  logic [N_BTN-1:0]         sync2;
  logic [N_BTN-1:0][DW-1:0] dcnt;
  logic [N_BTN-1:0][RW-1:0] rcnt;
  logic [N_BTN-1:0]         armed;
  logic [1:0]               warm;
  state_t                   state [N_BTN];

  // Next-state values
  logic [N_BTN-1:0]         level_n;
  logic [N_BTN-1:0]         press_n;
  logic [N_BTN-1:0]         release_n;
  logic [N_BTN-1:0]         repeat_n;
  logic [N_BTN-1:0][DW-1:0] dcnt_n;
  logic [N_BTN-1:0][RW-1:0] rcnt_n;
  logic [N_BTN-1:0]         armed_n;
  state_t                   state_n [N_BTN];

  logic [N_BTN-1:0] s;
  logic             warm_done;
  logic [N_BTN-1:0] accept;

  assign s = sync2;

  // The synchroniser holds reset zeros for two edges after reset exit, so the
  // channel's true input is only known once warm reaches 2.
  assign warm_done = (warm == 2'd2);

  // A channel becomes "armed" once it has been seen settled (s == level) with
  // real input data, or after its first acceptance. An acceptance on an
  // unarmed channel is a button already held through reset: the level is
  // reported but no press pulse is produced.
  always_comb begin
    level_n   = btn_level;
    press_n   = '0;
    release_n = '0;
    repeat_n  = '0;
    dcnt_n    = dcnt;
    rcnt_n    = rcnt;
    armed_n   = armed;
    accept    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_n[i] = state[i];

      // Debounce
      if (s[i] == btn_level[i]) begin
        dcnt_n[i] = '0;
        if (warm_done) armed_n[i] = 1'b1;
      end else if (dcnt[i] == D_LAST) begin
        accept[i]    = 1'b1;
        level_n[i]   = s[i];
        dcnt_n[i]    = '0;
        press_n[i]   = s[i] & armed[i];
        release_n[i] = ~s[i];
        armed_n[i]   = 1'b1;
      end else begin
        dcnt_n[i] = dcnt[i] + 1'b1;
      end

      // Repeat FSM; an accepted edge overrides any repeat tick in this cycle
      if (accept[i] && !s[i]) begin
        state_n[i] = ST_IDLE;
        rcnt_n[i]  = '0;
      end else if (accept[i] && s[i]) begin
        state_n[i] = ST_HELD;
        rcnt_n[i]  = '0;
      end else begin
        case (state[i])
          ST_HELD: begin
            if (REPEAT_DELAY > 0) begin
              if (rcnt[i] == DELAY_LAST) begin
                repeat_n[i] = 1'b1;
                rcnt_n[i]   = '0;
                state_n[i]  = ST_REPEATING;
              end else if (rcnt[i] != R_SAT) begin
                rcnt_n[i] = rcnt[i] + 1'b1;
              end
            end
          end
          ST_REPEATING: begin
            if (rcnt[i] == RATE_LAST) begin
              repeat_n[i] = 1'b1;
              rcnt_n[i]   = '0;
            end else if (rcnt[i] != R_SAT) begin
              rcnt_n[i] = rcnt[i] + 1'b1;
            end
          end
          default: begin
            rcnt_n[i] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      dcnt        <= '0;
      rcnt        <= '0;
      armed       <= '0;
      warm        <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      for (int i = 0; i < N_BTN; i++) state[i] <= ST_IDLE;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      dcnt        <= dcnt_n;
      rcnt        <= rcnt_n;
      armed       <= armed_n;
      if (!warm_done) warm <= warm + 2'd1;
      btn_level   <= level_n;
      btn_press   <= press_n;
      btn_release <= release_n;
      btn_repeat  <= repeat_n;
      for (int i = 0; i < N_BTN; i++) state[i] <= state_n[i];
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce
//   Directed bench for btn_debounce. Main instance: DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_RATE=3, N_BTN=3. A second instance built with
//   REPEAT_DELAY=0 shares clock and reset.
module tb_btn_debounce;

  logic       clk;
  logic       rst;
  logic [2:0] raw,  lvl,  prs,  rel,  rep;
  logic [2:0] raw0, lvl0, prs0, rel0, rep0;

  int total;
  int bad;

  btn_debounce #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(raw),
    .btn_level(lvl), .btn_press(prs), .btn_release(rel), .btn_repeat(rep)
  );

  btn_debounce #(
    .N_BTN(3), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_RATE(3)
  ) dut_norep (
    .clk(clk), .rst(rst), .btn_raw(raw0),
    .btn_level(lvl0), .btn_press(prs0), .btn_release(rel0), .btn_repeat(rep0)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; sample 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] e_lvl, input logic [2:0] e_prs,
                         input logic [2:0] e_rel, input logic [2:0] e_rep);
    chk({tag, ".level"},   {29'd0, lvl}, {29'd0, e_lvl});
    chk({tag, ".press"},   {29'd0, prs}, {29'd0, e_prs});
    chk({tag, ".release"}, {29'd0, rel}, {29'd0, e_rel});
    chk({tag, ".repeat"},  {29'd0, rep}, {29'd0, e_rep});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    raw   = 3'b111;
    raw0  = 3'b000;

    // 1. Reset with all buttons held
    #1 rst = 1'b1;
    #1 chk_all("rst_async", 3'b000, 3'b000, 3'b000, 3'b000);
    step(); step(); step();
    chk_all("rst_held", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk_all("rst_exit_wait", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    step();
    chk_all("rst_exit_level", 3'b111, 3'b000, 3'b000, 3'b000);
    // Start a release count, then reset mid-count
    raw = 3'b000;
    step(); step(); step();
    chk("mid_count_level", {29'd0, lvl}, 32'd7);
    #1 rst = 1'b1;
    #1 chk_all("rst_mid_count", 3'b000, 3'b000, 3'b000, 3'b000);
    step(); step();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) step();
    chk_all("post_reset_idle", 3'b000, 3'b000, 3'b000, 3'b000);

    // 2. Clean press / release on channel 0
    raw = 3'b001;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("press0", (k == 6) ? 3'b001 : 3'b000, (k == 6) ? 3'b001 : 3'b000,
              3'b000, 3'b000);
    end
    step();
    chk_all("press0_after", 3'b001, 3'b000, 3'b000, 3'b000);
    raw = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("release0", (k == 6) ? 3'b000 : 3'b001, 3'b000,
              (k == 6) ? 3'b001 : 3'b000, 3'b000);
    end
    step();
    chk_all("release0_after", 3'b000, 3'b000, 3'b000, 3'b000);

    // 3. Glitches on channel 1 shorter than the debounce window
    for (int g = 0; g < 5; g++) begin
      raw = 3'b010;
      for (int k = 0; k < 3; k++) begin
        step();
        chk_all("glitch1", 3'b000, 3'b000, 3'b000, 3'b000);
      end
      raw = 3'b000;
      for (int k = 0; k < 3; k++) begin
        step();
        chk_all("glitch1", 3'b000, 3'b000, 3'b000, 3'b000);
      end
    end
    raw = 3'b010;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("press1", (k == 6) ? 3'b010 : 3'b000, (k == 6) ? 3'b010 : 3'b000,
              3'b000, 3'b000);
    end
    step();
    chk_all("press1_after", 3'b010, 3'b000, 3'b000, 3'b000);
    raw = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("release1", (k == 6) ? 3'b000 : 3'b010, 3'b000,
              (k == 6) ? 3'b010 : 3'b000, 3'b000);
    end

    // 4. Auto-repeat on channel 2; release lands on a repeat slot
    raw = 3'b100;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("press2", (k == 6) ? 3'b100 : 3'b000, (k == 6) ? 3'b100 : 3'b000,
              3'b000, 3'b000);
    end
    for (int k = 1; k <= 31; k++) begin
      step();
      chk_all("repeat2", (k < 31) ? 3'b100 : 3'b000, 3'b000,
              (k == 31) ? 3'b100 : 3'b000,
              (k >= 10 && k < 31 && ((k - 10) % 3) == 0) ? 3'b100 : 3'b000);
      if (k == 25) raw = 3'b000;
    end
    step();
    chk_all("repeat2_after", 3'b000, 3'b000, 3'b000, 3'b000);

    // 5. All channels together, then an independent release of channel 1
    raw = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("press_all", (k == 6) ? 3'b111 : 3'b000, (k == 6) ? 3'b111 : 3'b000,
              3'b000, 3'b000);
    end
    raw = 3'b101;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("release_mid", (k == 6) ? 3'b101 : 3'b111, 3'b000,
              (k == 6) ? 3'b010 : 3'b000, 3'b000);
    end
    raw = 3'b000;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk_all("release_outer", (k == 6) ? 3'b000 : 3'b101, 3'b000,
              (k == 6) ? 3'b101 : 3'b000, (k == 4) ? 3'b101 : 3'b000);
    end

    // 6. Build with repeat disabled: held buttons never repeat
    raw0 = 3'b111;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("norep_press", {29'd0, prs0}, (k == 6) ? 32'd7 : 32'd0);
    end
    for (int k = 1; k <= 100; k++) begin
      step();
      chk("norep_repeat", {29'd0, rep0}, 32'd0);
      chk("norep_level", {29'd0, lvl0}, 32'd7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
